// File: rtl/cfg_ram_wr_ctrl_if.sv
// rtl/cfg_ram_wr_ctrl_if.sv - host command stream and shared config RAM write bus
interface cfg_ram_wr_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        s_last;
  logic [6:0]  addr_wr;
  logic [7:0]  sram_sel;
  logic        wr_en;
  logic [63:0] din;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, addr_wr, sram_sel, wr_en, din
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, addr_wr, sram_sel, wr_en, din
  );
endinterface

// File: rtl/cfg_ram_wr_ctrl.sv
// rtl/cfg_ram_wr_ctrl.sv - decodes header+data bursts into the config RAM write bus
module cfg_ram_wr_ctrl #(
  parameter int NUM_GROUPS     = 4,
  parameter int RAMS_PER_GROUP = 9,
  parameter int MAX_DEPTH      = 128
) (
  input  logic               clk,
  input  logic               rst,
  cfg_ram_wr_ctrl_if.slave   bus,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        wr_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  sel_q, sel_d;
  logic [6:0]  addr_q, addr_d;
  logic [6:0]  rem_q, rem_d;
  logic        wr_en_q, wr_en_d;
  logic [63:0] din_q, din_d;
  logic [6:0]  addr_wr_q, addr_wr_d;
  logic [7:0]  sram_sel_q, sram_sel_d;
  logic        err_q, err_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic        s_ready_int;
  logic        accept;
  logic [7:0]  hdr_magic;
  logic [7:0]  hdr_group;
  logic [3:0]  hdr_ram;
  logic [6:0]  hdr_start;
  logic [6:0]  hdr_len;
  logic [8:0]  hdr_end;
  logic [7:0]  hdr_sel;
  logic        hdr_bad;
  logic        unused_hdr_bits;

  assign hdr_magic = bus.s_data[63:56];
  assign hdr_group = bus.s_data[7:0];
  assign hdr_ram   = bus.s_data[11:8];
  assign hdr_start = bus.s_data[18:12];
  assign hdr_len   = bus.s_data[25:19];
  assign unused_hdr_bits = ^bus.s_data[55:26];

  // End address is formed in 9 bits so start+len cannot wrap past the depth check.
  assign hdr_end = {2'b00, hdr_start} + {2'b00, hdr_len} + 9'd1;
  assign hdr_sel = hdr_group * 8'(RAMS_PER_GROUP) + {4'd0, hdr_ram};
  assign hdr_bad = (hdr_magic != 8'hC5)
                || (hdr_group >= 8'(NUM_GROUPS))
                || (hdr_ram >= 4'(RAMS_PER_GROUP))
                || (hdr_end > 9'(MAX_DEPTH))
                || bus.s_last;

  // Ready is withheld while in reset so nothing is accepted in the reset cycle.
  assign s_ready_int = ~rst && (state_q != ST_DONE);
  assign accept      = bus.s_valid && s_ready_int;

  assign bus.s_ready  = s_ready_int;
  assign bus.wr_en    = wr_en_q && ~rst;
  assign bus.din      = din_q;
  assign bus.addr_wr  = addr_wr_q;
  assign bus.sram_sel = sram_sel_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign err          = err_q;
  assign wr_count     = wr_count_q;

  // Next-state and write-bus decode; the write is registered so it lands one cycle after acceptance.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    wr_en_d    = 1'b0;
    din_d      = din_q;
    addr_wr_d  = addr_wr_q;
    sram_sel_d = sram_sel_q;
    err_d      = err_q;
    wr_count_d = wr_count_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d = 1'b0;
          if (hdr_bad) begin
            err_d   = 1'b1;
            state_d = bus.s_last ? ST_IDLE : ST_DRAIN;
          end else begin
            sel_d   = hdr_sel;
            addr_d  = hdr_start;
            rem_d   = hdr_len;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          wr_en_d    = 1'b1;
          din_d      = bus.s_data;
          addr_wr_d  = addr_q;
          sram_sel_d = sel_q;
          addr_d     = addr_q + 7'd1;
          wr_count_d = wr_count_q + 16'd1;
          if (rem_q == 7'd0) begin
            if (bus.s_last) begin
              state_d = ST_DONE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end
          end else begin
            rem_d = rem_q - 7'd1;
            if (bus.s_last) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (accept && bus.s_last) begin
          state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= 8'd0;
      addr_q     <= 7'd0;
      rem_q      <= 7'd0;
      wr_en_q    <= 1'b0;
      din_q      <= 64'd0;
      addr_wr_q  <= 7'd0;
      sram_sel_q <= 8'd0;
      err_q      <= 1'b0;
      wr_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wr_en_q    <= wr_en_d;
      din_q      <= din_d;
      addr_wr_q  <= addr_wr_d;
      sram_sel_q <= sram_sel_d;
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_cfg_ram_wr_ctrl.sv
// tb/tb_cfg_ram_wr_ctrl.sv - scoreboard bench for cfg_ram_wr_ctrl
module tb_cfg_ram_wr_ctrl;

  logic        clk;
  logic        rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] wr_count;

  cfg_ram_wr_ctrl_if bus();

  cfg_ram_wr_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .wr_count (wr_count)
  );

  typedef struct {
    logic [7:0]  sel;
    logic [6:0]  addr;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks;
  int  errors;
  int  cyc;
  int  done_seen;
  int  last_wait;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] hdr(input logic [7:0] mg, input logic [7:0] g,
                                      input logic [3:0] r, input logic [6:0] st,
                                      input logic [6:0] l);
    hdr = {mg, 30'd0, l, st, r, g};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pops one expected write for every strobe the DUT presents.
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (bus.wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_write: sel=%0d addr=%0d din=%0h cyc=%0d, none expected",
                   bus.sram_sel, bus.addr_wr, bus.din, cyc);
        end else begin
          e = exp_q.pop_front();
          if (bus.sram_sel !== e.sel || bus.addr_wr !== e.addr || bus.din !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL write: got sel=%0d addr=%0d din=%0h cyc=%0d expected sel=%0d addr=%0d din=%0h cyc=%0d",
                     bus.sram_sel, bus.addr_wr, bus.din, cyc, e.sel, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic send(input logic [63:0] w, input logic l, input logic exp_wr,
                      input logic [7:0] es, input logic [6:0] ea);
    wr_t e;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    bus.s_last  = l;
    last_wait   = 0;
    while (bus.s_ready !== 1'b1 && last_wait < 16) begin
      @(posedge clk);
      #1;
      last_wait++;
    end
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: word %0h not accepted after %0d cycles", w, last_wait);
      bus.s_valid = 1'b0;
    end else begin
      if (exp_wr) begin
        e.sel  = es;
        e.addr = ea;
        e.data = w;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; done_seen = 0; last_wait = 0;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 64'd0;
    bus.s_last  = 1'b0;
    fork
      monitor();
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", {63'd0, bus.s_ready}, 64'd0);
    chk("rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
    chk("rst_addr_wr", {57'd0, bus.addr_wr}, 64'd0);
    chk("rst_sram_sel", {56'd0, bus.sram_sel}, 64'd0);
    chk("rst_din", bus.din, 64'd0);
    chk("rst_busy_done_err", {61'd0, busy, done, err}, 64'd0);
    chk("rst_wr_count", {48'd0, wr_count}, 64'd0);
    rst = 1'b0;
    #0;
    chk("idle_s_ready", {63'd0, bus.s_ready}, 64'd1);

    // Valid burst: group 1 ram 2 -> sel 11, addr 5..7
    send(hdr(8'hC5, 8'd1, 4'd2, 7'd5, 7'd2), 1'b0, 1'b0, 8'd0, 7'd0);
    send(64'hA, 1'b0, 1'b1, 8'd11, 7'd5);
    send(64'hB, 1'b0, 1'b1, 8'd11, 7'd6);
    send(64'hC, 1'b1, 1'b1, 8'd11, 7'd7);
    chk("done_state", {61'd0, bus.s_ready, done, busy}, 64'b011);
    idle(2);
    chk("t1_wr_count", {48'd0, wr_count}, 64'd3);
    chk("t1_err", {63'd0, err}, 64'd0);
    chk("t1_done_seen", done_seen, 1);

    // Bad magic, drained with ready held high
    send(hdr(8'h00, 8'd1, 4'd2, 7'd5, 7'd2), 1'b0, 1'b0, 8'd0, 7'd0);
    chk("bad_magic_err_busy", {62'd0, err, busy}, 64'b11);
    for (int i = 0; i < 4; i++) begin
      send(64'h100 + 64'(i), (i == 3), 1'b0, 8'd0, 7'd0);
      chk("drain_ready_wait", last_wait, 0);
    end
    chk("drain_end_err_busy", {62'd0, err, busy}, 64'b10);
    send(hdr(8'hC5, 8'd0, 4'd0, 7'd0, 7'd0), 1'b0, 1'b0, 8'd0, 7'd0);
    chk("hdr_clears_err", {63'd0, err}, 64'd0);
    send(64'h1234, 1'b1, 1'b1, 8'd0, 7'd0);
    idle(2);

    // Range violation (126+3+1 = 130 > 128), then bad ram index / group
    send(hdr(8'hC5, 8'd0, 4'd0, 7'd126, 7'd3), 1'b0, 1'b0, 8'd0, 7'd0);
    send(64'h55, 1'b1, 1'b0, 8'd0, 7'd0);
    chk("range_err_busy", {62'd0, err, busy}, 64'b10);
    send(hdr(8'hC5, 8'd0, 4'd9, 7'd0, 7'd0), 1'b1, 1'b0, 8'd0, 7'd0);
    chk("ram9_err_busy", {62'd0, err, busy}, 64'b10);
    send(hdr(8'hC5, 8'd4, 4'd0, 7'd0, 7'd0), 1'b1, 1'b0, 8'd0, 7'd0);
    chk("grp4_err_busy", {62'd0, err, busy}, 64'b10);
    // Boundary: end exactly 128, group 3 ram 8 -> sel 35
    send(hdr(8'hC5, 8'd3, 4'd8, 7'd125, 7'd2), 1'b0, 1'b0, 8'd0, 7'd0);
    chk("boundary_hdr_ok", {62'd0, err, busy}, 64'b01);
    send(64'h200, 1'b0, 1'b1, 8'd35, 7'd125);
    send(64'h201, 1'b0, 1'b1, 8'd35, 7'd126);
    send(64'h202, 1'b1, 1'b1, 8'd35, 7'd127);
    idle(2);
    chk("t3_wr_count", {48'd0, wr_count}, 64'd7);

    // Early s_last: group 2 ram 0 -> sel 18
    send(hdr(8'hC5, 8'd2, 4'd0, 7'd10, 7'd4), 1'b0, 1'b0, 8'd0, 7'd0);
    send(64'hD1, 1'b0, 1'b1, 8'd18, 7'd10);
    send(64'hD2, 1'b1, 1'b1, 8'd18, 7'd11);
    chk("early_err_busy", {62'd0, err, busy}, 64'b10);
    idle(2);
    chk("early_no_done", done_seen, 3);

    // Overrun: one-word burst fed three words, sel 5
    send(hdr(8'hC5, 8'd0, 4'd5, 7'd0, 7'd0), 1'b0, 1'b0, 8'd0, 7'd0);
    send(64'hE1, 1'b0, 1'b1, 8'd5, 7'd0);
    chk("overrun_err_busy", {62'd0, err, busy}, 64'b11);
    send(64'hE2, 1'b0, 1'b0, 8'd0, 7'd0);
    idle(3);
    send(64'hE3, 1'b1, 1'b0, 8'd0, 7'd0);
    chk("overrun_end_busy", {63'd0, busy}, 64'd0);
    // Gaps mid-DATA: group 1 ram 0 -> sel 9
    send(hdr(8'hC5, 8'd1, 4'd0, 7'd20, 7'd1), 1'b0, 1'b0, 8'd0, 7'd0);
    send(64'h77, 1'b0, 1'b1, 8'd9, 7'd20);
    idle(3);
    send(64'h78, 1'b1, 1'b1, 8'd9, 7'd21);
    idle(2);
    chk("t5_wr_count", {48'd0, wr_count}, 64'd12);
    chk("t5_done_seen", done_seen, 4);
    chk("t5_err", {63'd0, err}, 64'd0);

    // Reset mid-burst: second word's write must be suppressed
    send(hdr(8'hC5, 8'd0, 4'd1, 7'd40, 7'd3), 1'b0, 1'b0, 8'd0, 7'd0);
    send(64'hF1, 1'b0, 1'b1, 8'd1, 7'd40);
    send(64'hF2, 1'b0, 1'b0, 8'd0, 7'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #0;
    chk("post_rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
    chk("post_rst_addr_sel", {49'd0, bus.sram_sel, bus.addr_wr}, 64'd0);
    chk("post_rst_din", bus.din, 64'd0);
    chk("post_rst_flags", {61'd0, busy, done, err}, 64'd0);
    chk("post_rst_wr_count", {48'd0, wr_count}, 64'd0);
    chk("post_rst_s_ready", {63'd0, bus.s_ready}, 64'd1);
    send(hdr(8'hC5, 8'd3, 4'd3, 7'd0, 7'd0), 1'b0, 1'b0, 8'd0, 7'd0);
    chk("fresh_hdr_wait", last_wait, 0);
    send(64'hABC, 1'b1, 1'b1, 8'd30, 7'd0);
    idle(3);
    chk("t6_wr_count", {48'd0, wr_count}, 64'd1);
    chk("t6_done_seen", done_seen, 5);
    chk("all_writes_seen", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
